ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the byte-addressed, combinational-read instruction memory. It owns the program counter, drives the memory address and captures the returned 32-bit word into an IF/ID output register. It hands {pc, instr} to decode over a valid/ready handshake and accepts PC redirects from branch/jump resolution. Illegal fetch addresses are reported as a fault entry, after which fetch halts until redirected.

Parameters:
IMEM_ADDR_W, 6, width of the instruction-memory byte address (memory size = 2**IMEM_ADDR_W bytes)
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction word emitted with fault entries (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
imem_addr  out  IMEM_ADDR_W  byte address to instruction memory, = pc_q[IMEM_ADDR_W-1:0]
imem_data  in  32  instruction word from memory, same-cycle (combinational) response
redirect_valid  in  1  load new PC this cycle, flush pending entry
redirect_pc  in  32  redirect target
out_valid  out  1  IF/ID entry valid
out_ready  in  1  decode accepts entry
out_pc  out  32  PC of presented instruction
out_instr  out  32  presented instruction word
out_fault  out  1  presented entry is a fetch fault (misaligned or out of range)
halted  out  1  fetch stopped after a fault

Behaviour:
- Reset (async assert, sync-to-clk release irrelevant): pc_q=RESET_PC, state=RUN, out_valid=0, out_pc=0, out_instr=0, out_fault=0, halted=0.
- imem_addr combinational from pc_q; imem_data is sampled in the same cycle. out_instr = imem_data unchanged (byte order fixed by memory: byte at addr is bits 31:24).
- bad_pc = (pc_q[1:0] != 0) OR (pc_q[31:IMEM_ADDR_W] != 0).
- load_en = (!out_valid OR out_ready).
- States: RUN, HALTED.
- RUN, no redirect, load_en, !bad_pc: out_valid<=1, out_pc<=pc_q, out_instr<=imem_data, out_fault<=0, pc_q<=pc_q+4 (32-bit wrap, no carry out).
- RUN, no redirect, load_en, bad_pc: out_valid<=1, out_pc<=pc_q, out_instr<=NOP_INSTR, out_fault<=1, pc_q unchanged, state<=HALTED, halted<=1.
- RUN, !load_en: all registers hold (stall); imem_addr stays stable.
- HALTED: no new loads; out_valid clears when the fault entry is accepted (out_valid&&out_ready -> out_valid<=0); halted stays 1.
- redirect_valid (any state, highest priority): pc_q<=redirect_pc, out_valid<=0, out_fault<=0, state<=RUN, halted<=0. Entry held that cycle is discarded even if out_ready=1. Redirect target is not fetched in the redirect cycle; first entry appears 1 cycle later (out_valid=1 at redirect+2 edges if load_en).
- Throughput: 1 instruction/cycle with out_ready held high; fetch latency PC->out_valid is 1 cycle.
- Top-of-memory: pc_q = 2**IMEM_ADDR_W-4 is legal; next pc = 2**IMEM_ADDR_W makes bad_pc=1 -> fault.
- Reset mid-stall or mid-fault: returns to reset values immediately, no entry leaks.

Decomposition:
- Shared package rv_pkg: XLEN=32, NOP_INSTR constant, fetch state enum {RUN, HALTED}, typedef of IF/ID entry struct {pc, instr, fault}.
- One natural sub-module: pipe_reg_ifid (valid/ready register with flush input) holding the IF/ID entry; PC logic and FSM stay in ifetch_unit.

Test Plan:
- Reset release, out_ready=1, memory holding words W0..W3 at 0,4,8,12 -> out_pc 0,4,8,12 on consecutive cycles, out_instr=W0..W3, out_fault=0.
- out_ready=0 for 3 cycles while out_valid=1 at pc 8 -> out_pc/out_instr/imem_addr hold at 8/W2; on release next entry pc 12.
- redirect_valid with redirect_pc=0x20 while entry pc 4 pending and out_ready=1 -> next cycle out_valid=0, following cycle out_pc=0x20, out_instr=mem word at 0x20.
- Sequential fetch to 0x3C (IMEM_ADDR_W=6) -> entry 0x3C normal, then entry pc=0x40, out_fault=1, out_instr=0x00000013, halted=1, no further entries.
- redirect_pc=0x06 -> fault entry pc=0x06 after 1 cycle, halted=1; later redirect_pc=0x00 -> halted=0, fetch resumes at 0.
- Assert rst mid-stream with out_valid=1 -> out_valid=0 immediately (async), after release first entry pc=RESET_PC.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types and constants for the instruction fetch stage.
package rv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- emitted in place of an instruction on a fetch fault
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // One IF/ID pipeline entry handed to decode
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } ifid_entry_t;

endpackage

// File: rtl/pipe_reg_ifid.sv
// IF/ID valid/ready pipeline register with a flush input that discards
// the held entry. It accepts a new entry whenever it is empty or its
// current entry is being consumed.
module pipe_reg_ifid
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  ifid_entry_t in_entry,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output ifid_entry_t out_entry
);

  logic        valid_reg;
  ifid_entry_t entry_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_entry = entry_reg;

  // Entry register: flush wins, otherwise load or drain when there is room
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      entry_reg <= '0;
    end else if (flush) begin
      valid_reg       <= 1'b0;
      entry_reg.fault <= 1'b0;
    end else if (in_ready) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        entry_reg <= in_entry;
      end
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational-read
// instruction memory and pushes {pc, instr, fault} into the IF/ID register.
// An illegal PC produces a single fault entry and halts fetch until a
// redirect arrives.
module ifetch_unit #(
  parameter int          IMEM_ADDR_W = 6,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = rv_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_data,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic                   out_fault,
  output logic                   halted
);

  import rv_pkg::*;

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         bad_pc;
  logic         load_en;
  logic         fetch_valid;
  ifid_entry_t  fetch_entry;
  ifid_entry_t  held_entry;

  // Misaligned, or beyond the top of the instruction memory
  assign bad_pc    = (pc_reg[1:0] != 2'b00) || ((pc_reg >> IMEM_ADDR_W) != 32'd0);
  assign imem_addr = pc_reg[IMEM_ADDR_W-1:0];
  assign halted    = (state_reg == HALTED);

  // PC and fetch state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      state_reg <= RUN;
    end else begin
      pc_reg    <= pc_next;
      state_reg <= state_next;
    end
  end

  // Next PC, next state and the entry offered to the IF/ID register
  always_comb begin
    pc_next           = pc_reg;
    state_next        = state_reg;
    fetch_valid       = 1'b0;
    fetch_entry.pc    = pc_reg;
    fetch_entry.instr = imem_data;
    fetch_entry.fault = 1'b0;
    if (redirect_valid) begin
      // Redirect target is fetched starting next cycle
      pc_next    = redirect_pc;
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN: begin
          if (load_en) begin
            fetch_valid = 1'b1;
            if (bad_pc) begin
              fetch_entry.instr = NOP_INSTR;
              fetch_entry.fault = 1'b1;
              state_next        = HALTED;
            end else begin
              pc_next = pc_reg + 32'd4;
            end
          end
        end
        HALTED: begin
          fetch_valid = 1'b0;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  pipe_reg_ifid u_ifid (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .in_valid  (fetch_valid),
    .in_entry  (fetch_entry),
    .in_ready  (load_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_entry (held_entry)
  );

  assign out_pc    = held_entry.pc;
  assign out_instr = held_entry.instr;
  assign out_fault = held_entry.fault;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: every (re)start of fetch pushes the
// full expected entry stream; a negedge monitor pops and compares each
// accepted entry. Directed timing checks precede a randomized phase.
module tb_ifetch_unit;

  localparam int          AW   = 6;
  localparam int          MEMB = 1 << AW;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_fault;
  logic          halted;

  logic [7:0] mem [MEMB];
  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;

  ifetch_unit #(.IMEM_ADDR_W(AW), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Big-endian byte memory: byte at addr lands in bits 31:24
  assign imem_data = {mem[imem_addr], mem[imem_addr + 6'd1],
                      mem[imem_addr + 6'd2], mem[imem_addr + 6'd3]};

  function automatic logic [31:0] word_at(input int p);
    return {mem[p], mem[p+1], mem[p+2], mem[p+3]};
  endfunction

  // Expected entries when fetch starts at 'start' and nothing interrupts:
  // sequential legal words, then one fault entry, then nothing.
  task automatic push_stream(input logic [31:0] start);
    longint p;
    exp_t   e;
    exp_q.delete();
    p = start;
    for (int n = 0; n < MEMB; n++) begin
      if ((p % 4) != 0 || p >= MEMB) begin
        e.pc = p[31:0]; e.instr = NOP; e.fault = 1'b1;
        exp_q.push_back(e);
        break;
      end
      e.pc = p[31:0]; e.instr = word_at(int'(p)); e.fault = 1'b0;
      exp_q.push_back(e);
      p = p + 4;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: an entry is consumed at an edge with valid&ready and no redirect
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready && !redirect_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_entry: got pc=%h instr=%h fault=%0d, expected none",
                 out_pc, out_instr, out_fault);
      end else begin
        e = exp_q.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr || out_fault !== e.fault ||
            (e.fault && halted !== 1'b1)) begin
          fails++;
          $display("FAIL entry: got pc=%h instr=%h fault=%0d halted=%0d, expected pc=%h instr=%h fault=%0d",
                   out_pc, out_instr, out_fault, halted, e.pc, e.instr, e.fault);
        end else begin
          $display("[TB] entry pc=%h instr=%h fault=%0d", out_pc, out_instr, out_fault);
        end
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    bool_loop: begin end
    for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_fault", {31'd0, out_fault}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    push_stream(32'd0);
    rst = 1'b0;

    // Back-to-back fetch
    for (int k = 0; k < 3; k++) begin
      step();
      check("seq_valid", {31'd0, out_valid}, 32'd1);
      check("seq_pc", out_pc, 32'(4 * k));
      check("seq_instr", out_instr, word_at(4 * k));
    end

    // Stall at pc 8 for three cycles
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_pc", out_pc, 32'd8);
      check("stall_instr", out_instr, word_at(8));
      check("stall_addr", {26'd0, imem_addr}, 32'd12);
    end
    out_ready = 1'b1;
    step();
    check("release_pc", out_pc, 32'd12);

    // Redirect to 0x20 with an entry pending
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    push_stream(32'h20);
    step();
    redirect_valid = 1'b0;
    check("redir_bubble", {31'd0, out_valid}, 32'd0);
    step();
    check("redir_valid", {31'd0, out_valid}, 32'd1);
    check("redir_pc", out_pc, 32'h20);
    check("redir_instr", out_instr, word_at(32'h20));

    // Run off the top of memory
    for (int k = 0; k < 20 && !out_fault; k++) step();
    check("top_fault", {31'd0, out_fault}, 32'd1);
    check("top_pc", out_pc, 32'h40);
    check("top_instr", out_instr, NOP);
    check("top_halted", {31'd0, halted}, 32'd1);
    repeat (3) step();
    check("halt_no_entry", {31'd0, out_valid}, 32'd0);
    check("halt_stays", {31'd0, halted}, 32'd1);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h06;
    push_stream(32'h06);
    step();
    redirect_valid = 1'b0;
    check("mis_unhalt", {31'd0, halted}, 32'd0);
    step();
    check("mis_pc", out_pc, 32'h06);
    check("mis_fault", {31'd0, out_fault}, 32'd1);
    check("mis_halted", {31'd0, halted}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h00;
    push_stream(32'h00);
    step();
    redirect_valid = 1'b0;
    check("resume_unhalt", {31'd0, halted}, 32'd0);
    step();
    check("resume_pc", out_pc, 32'h00);

    // Asynchronous reset mid-stream
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    push_stream(32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_pc", out_pc, 32'd0);

    // Randomized stalls, redirects and occasional resets
    for (int c = 0; c < 600; c++) begin
      step();
      redirect_valid = 1'b0;
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        push_stream(32'd0);
      end else if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 5))
          0: tgt = 32'($urandom_range(0, MEMB - 1));
          1: tgt = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2);
          default: tgt = 32'($urandom_range(0, MEMB / 4 - 1)) << 2;
        endcase
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        push_stream(tgt);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain: every stream ends in a fault, so fetch must end halted and empty
    step();
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    repeat (40) step();
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_halted", {31'd0, halted}, 32'd1);
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
